alu_mc: RTL
===========

# alu_mc

Multi-cycle, parametrised execute-stage ALU. It supersedes the single-cycle combinational ALU and adds:
- a registered valid/ready handshake,
- a signed iterative shift-add multiplier (`ALUOP_MUL`),
- a flush input,
- an illegal-opcode flag.

It sits between the ID/EX pipeline register and the EX/MEM register. The exec-stage control holds the pipeline while `in_ready` is low.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the multiplier iteration counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  aborts any in-flight operation; has the same effect as reset on the FSM and on `out_valid`.
- `in_valid`  in  1  the operation on `aluop`/`src1`/`src2` is valid.
- `in_ready`  out  1  the block can accept an operation this cycle.
- `aluop`  in  8  opcode, using the `ALUOP_*` encodings from `define.v`.
- `src1`, `src2`  in  `WIDTH`  operands, two's complement.
- `out_valid`  out  1  one-cycle pulse; result outputs are new this cycle.
- `out`  out  `WIDTH`  result (low half for MUL).
- `out_hi`  out  `WIDTH`  high half of the MUL product; 0 for all other ops.
- `zero`  out  1  BEQ comparison result.
- `overflow`  out  1  signed overflow.
- `illegal`  out  1  the accepted opcode is not in the supported set.

## Operation
- An operation is accepted when `in_valid && in_ready` at a rising edge.
- Results are registered and hold their values until the next `out_valid`.
- FSM states:
  - **IDLE**: `in_ready` = 1.
    - Accepting a non-MUL op registers its result and pulses `out_valid` next cycle; the state stays IDLE, so back-to-back ops are allowed.
    - Accepting MUL latches `|src1|`, `|src2|` and `sign = src1[W-1]^src2[W-1]`, loads the counter with `WIDTH`, and moves to **MUL_RUN**.
  - **MUL_RUN**: `in_ready` = 0.
    - Each cycle: if the multiplier LSB is 1, add the multiplicand into the 2W-bit accumulator.
    - Then shift the accumulator/multiplier right by one and decrement the counter.
    - When the counter reaches 0, go to **MUL_FIX**.
  - **MUL_FIX**: `in_ready` = 0.
    - Negate the 2W-bit product if `sign` = 1.
    - Register `out` = low half and `out_hi` = high half.
    - Set `overflow = (out_hi != {WIDTH{out[W-1]}})`.
    - Pulse `out_valid` and return to IDLE.
- Per-op results; `zero`, `overflow` and `illegal` are 0 unless stated:
  - ADD: `out = src1 + src2` (mod 2^W). `overflow` = operand signs equal AND result sign differs from the operands, computed from the new sum, never the stale `out`.
  - SUB: `out = src1 - src2`. `overflow` = operand signs differ AND result sign differs from `src1`.
  - LDB, STB: `out = src1 + src2`.
  - LDW, STW: `out = (src1 + src2)` with bits [1:0] cleared (word-aligned address).
  - MOV: `out = src1`.
  - BEQ: `out = 0`; `zero = (src1 == src2)`.
  - JUMP: `out = 0`.
  - Any other opcode: `out = 0`, `illegal = 1`; the result still completes with an `out_valid` pulse.
- For every non-MUL op, `out_hi` = 0.

## Timing
- Reset and flush values:
  - `in_ready` = 1 and `out_valid` = 0 in the cycle after the reset/flush edge.
  - `out`, `out_hi`, `zero`, `overflow`, `illegal` reset to 0.
  - Flush does not clear the result registers.
- Latency, with C = acceptance cycle:
  - Non-MUL: `out_valid` in C+1. Throughput is 1 op/cycle.
  - MUL: MUL_RUN in C+1..C+WIDTH, MUL_FIX in C+WIDTH+1, `out_valid` in C+WIDTH+2.
  - `in_ready` is low in C+1..C+WIDTH+1 and high again in C+WIDTH+2.
  - For `WIDTH` = 32: `out_valid` in C+34.
- `in_valid` while `in_ready` = 0 is ignored. Upstream must hold the request stable.
- Flush or reset in any MUL cycle, including MUL_FIX: no `out_valid` for the aborted op, and the state is IDLE next cycle.
- Flush and `in_valid` in the same cycle: the flush wins and nothing is accepted.
- Operand edge cases:
  - The most-negative operand has magnitude 2^(W-1), which fits the unsigned W-bit latch.
  - A zero operand completes in full latency; there is no early termination.

## Test plan
- ADD `0x7FFFFFFF` + `0x00000001` -> C+1: `out_valid`=1, `out`=`0x80000000`, `overflow`=1; then SUB `0x80000000` - 1 in C+1 -> C+2: `out`=`0x7FFFFFFF`, `overflow`=1.
- BEQ 5,5 -> `zero`=1, `out`=0; BEQ 5,6 -> `zero`=0. LDW `0x1001`+`0x2` -> `out`=`0x1000`.
- MUL `0xFFFFFFFD` (-3) × 7 at C -> `in_ready`=0 in C+1..C+33; C+34: `out`=`0xFFFFFFEB`, `out_hi`=`0xFFFFFFFF`, `overflow`=0, `out_valid` for exactly 1 cycle.
- MUL `0x80000000` × `0xFFFFFFFF` -> `out`=`0x80000000`, `out_hi`=0, `overflow`=1. MUL 0 × 0 -> all zero, still C+34.
- MUL accepted at C, flush at C+10 -> no `out_valid` through C+40, `in_ready`=1 at C+11; ADD 2+3 at C+11 -> `out`=5 at C+12.
- `aluop`=`0xFF` (unused) -> `out_valid`=1, `illegal`=1, `out`=0; `reset` asserted in the MUL_FIX cycle -> no `out_valid`, all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU. Single-cycle ops complete in one
// clock; MUL uses an iterative signed shift-add multiplier behind an in_ready
// handshake. Flush aborts in-flight work without clearing the result registers.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       aluop,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [7:0] ALUOP_ADD  = 8'h01;
  localparam logic [7:0] ALUOP_SUB  = 8'h02;
  localparam logic [7:0] ALUOP_LDB  = 8'h03;
  localparam logic [7:0] ALUOP_LDW  = 8'h04;
  localparam logic [7:0] ALUOP_STB  = 8'h05;
  localparam logic [7:0] ALUOP_STW  = 8'h06;
  localparam logic [7:0] ALUOP_MOV  = 8'h07;
  localparam logic [7:0] ALUOP_BEQ  = 8'h08;
  localparam logic [7:0] ALUOP_JUMP = 8'h09;
  localparam logic [7:0] ALUOP_MUL  = 8'h0A;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_FIX} state_t;

  // Magnitude of a two's complement value; the most-negative value maps to
  // 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Conditional two's complement negation of the full 2W-bit product.
  function automatic logic [2*WIDTH-1:0] neg_cond(input logic [2*WIDTH-1:0] p,
                                                  input logic s);
    return s ? (~p + 1'b1) : p;
  endfunction

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
  logic                    accept, is_mul;
  logic [WIDTH-1:0]        res_out;
  logic                    res_zero, res_ovf, res_ill;

  logic [WIDTH-1:0]        mcand_p0;
  logic [2*WIDTH:0]        prod_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    sign_p0;
  logic [WIDTH:0]          hi_sum;
  logic [2*WIDTH-1:0]      fix_prod;

  assign in_ready = (state == IDLE);
  assign is_mul   = (aluop == ALUOP_MUL);
  assign accept   = in_valid && in_ready && !flush;
  assign a_s      = src1;
  assign b_s      = src2;
  assign sum_s    = a_s + b_s;
  assign diff_s   = a_s - b_s;

  assign hi_sum   = prod_p0[2*WIDTH:WIDTH] + (prod_p0[0] ? {1'b0, mcand_p0} : '0);
  assign fix_prod = neg_cond(prod_p0[2*WIDTH-1:0], sign_p0);

  // Single-cycle op results, computed from the incoming operands.
  always_comb begin
    res_out  = '0;
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_ill  = 1'b0;
    case (aluop)
      ALUOP_ADD: begin
        res_out = sum_s;
        res_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      ALUOP_SUB: begin
        res_out = diff_s;
        res_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      ALUOP_LDB, ALUOP_STB: res_out = sum_s;
      ALUOP_LDW, ALUOP_STW: res_out = {sum_s[WIDTH-1:2], 2'b00};
      ALUOP_MOV:            res_out = src1;
      ALUOP_BEQ:            res_zero = (src1 == src2);
      ALUOP_JUMP:           res_out = '0;
      default:              res_ill = 1'b1;
    endcase
  end

  // Next-state logic: MUL_RUN lasts exactly WIDTH cycles, no early exit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL_RUN;
      MUL_RUN: if (cnt_p0 == CNT_W'(1)) state_nxt = MUL_FIX;
      MUL_FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; flush behaves like reset on the FSM.
  always_ff @(posedge clk) begin
    if (reset || flush) state <= IDLE;
    else                state <= state_nxt;
  end

  // Multiplier stage p0: latch magnitudes on accept, then shift-add per cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept && is_mul) begin
      mcand_p0 <= mag(a_s);
      prod_p0  <= {{(WIDTH+1){1'b0}}, mag(b_s)};
      sign_p0  <= src1[WIDTH-1] ^ src2[WIDTH-1];
      cnt_p0   <= CNT_W'(WIDTH);
    end else if (state == MUL_RUN) begin
      prod_p0  <= {hi_sum, prod_p0[WIDTH-1:0]} >> 1;
      cnt_p0   <= cnt_p0 - 1'b1;
    end
  end

  // Result registers: updated on single-cycle accept or at MUL_FIX; held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept && !is_mul) begin
        out_valid <= 1'b1;
        out       <= res_out;
        out_hi    <= '0;
        zero      <= res_zero;
        overflow  <= res_ovf;
        illegal   <= res_ill;
      end else if (state == MUL_FIX) begin
        out_valid <= 1'b1;
        out       <= fix_prod[WIDTH-1:0];
        out_hi    <= fix_prod[2*WIDTH-1:WIDTH];
        zero      <= 1'b0;
        overflow  <= (fix_prod[2*WIDTH-1:WIDTH] != {WIDTH{fix_prod[WIDTH-1]}});
        illegal   <= 1'b0;
      end
    end
  end

endmodule
